// File: rtl/rt_lim_preload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rt_lim_preload_ctrl
// Purpose  : Preload sequencer and port-B owner for the racetrack LiM data RAM.
//            On start_i it streams source words into consecutive memory words
//            with plain writes (LiM function fields held at zero), pacing each
//            write on the rvalid completion, then raises fetch_enable_o.
//            Outside a preload the core data port is passed straight through.
// Revision : 1.0 - initial release
// ============================================================================
module rt_lim_preload_ctrl #(
  parameter int                    ADDR_WIDTH     = 22,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    FUNCT_WIDTH    = 4,
  parameter int                    MAX_WORDS      = 4153,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [$clog2(MAX_WORDS+1)-1:0]   num_words_i,
  input  logic                             src_valid_i,
  input  logic [DATA_WIDTH-1:0]            src_data_i,
  output logic                             src_ready_o,
  input  logic                             core_req_i,
  input  logic [ADDR_WIDTH-1:0]            core_addr_i,
  input  logic                             core_we_i,
  input  logic [DATA_WIDTH/8-1:0]          core_be_i,
  input  logic [DATA_WIDTH-1:0]            core_wdata_i,
  input  logic [FUNCT_WIDTH-1:0]           core_funct_i,
  input  logic                             core_we_funct_i,
  output logic                             core_gnt_o,
  output logic                             mem_en_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic                             mem_we_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  output logic [FUNCT_WIDTH-1:0]           mem_funct_o,
  output logic                             mem_we_funct_o,
  input  logic                             mem_rvalid_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o,
  output logic                             fetch_enable_o
);

  localparam int CNT_W = $clog2(MAX_WORDS+1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DRAIN      = 3'd1;
  localparam logic [2:0] ST_WAIT_SRC   = 3'd2;
  localparam logic [2:0] ST_ISSUE      = 3'd3;
  localparam logic [2:0] ST_WAIT_VALID = 3'd4;
  localparam logic [2:0] ST_GAP        = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;
  localparam logic [2:0] ST_ERROR      = 3'd7;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [CNT_W-1:0]      idx;
  logic [CNT_W-1:0]      idx_inc;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] word;
  logic [TO_W-1:0]       tmo_cnt;
  logic                  core_pend;
  logic                  fetch_seen;
  logic                  in_pass;
  logic [ADDR_WIDTH-1:0] pre_addr;

  // The core owns port B only in the non-preloading states.
  assign in_pass  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign idx_inc  = idx + CNT_W'(1);
  // Word index to byte address; wraps modulo the port-B address space.
  assign pre_addr = BASE_ADDR + ADDR_WIDTH'({idx, 2'b00});

  // Next-state selection for the preload sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start_i) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!core_pend) state_nxt = (count == '0) ? ST_DONE : ST_WAIT_SRC;
      end
      ST_WAIT_SRC: if (src_valid_i) state_nxt = ST_ISSUE;
      ST_ISSUE:    state_nxt = mem_rvalid_i ? ST_GAP : ST_WAIT_VALID;
      ST_WAIT_VALID: begin
        if (mem_rvalid_i)             state_nxt = ST_GAP;
        else if (tmo_cnt == TO_LAST)  state_nxt = ST_ERROR;
      end
      ST_GAP:  state_nxt = (idx_inc == count) ? ST_DONE : ST_WAIT_SRC;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any preload in flight immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Preload datapath: word count, index, captured word and rvalid timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count   <= '0;
      idx     <= '0;
      word    <= '0;
      tmo_cnt <= '0;
    end else begin
      if (in_pass && start_i) begin
        count <= num_words_i;
        idx   <= '0;
      end
      if (state == ST_WAIT_SRC && src_valid_i) word <= src_data_i;
      if (state == ST_ISSUE)           tmo_cnt <= '0;
      else if (state == ST_WAIT_VALID) tmo_cnt <= tmo_cnt + TO_W'(1);
      if (state == ST_GAP) idx <= idx_inc;
    end
  end

  // Track a granted core access whose completion has not yet returned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     core_pend <= 1'b0;
    else if (in_pass && core_req_i) core_pend <= 1'b1;
    else if (mem_rvalid_i)          core_pend <= 1'b0;
  end

  // Once a preload has completed, fetch stays enabled until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  fetch_seen <= 1'b0;
    else if (state == ST_DONE)  fetch_seen <= 1'b1;
  end

  // Port-B mux: core passthrough, or the sequencer's plain word write.
  // Reset forces every port-B output low so nothing leaks out mid-abort.
  always_comb begin
    mem_en_o       = 1'b0;
    mem_addr_o     = '0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_wdata_o    = '0;
    mem_funct_o    = '0;
    mem_we_funct_o = 1'b0;
    core_gnt_o     = 1'b0;
    if (!rst_i) begin
      if (in_pass) begin
        mem_en_o       = core_req_i;
        mem_addr_o     = core_addr_i;
        mem_we_o       = core_we_i;
        mem_be_o       = core_be_i;
        mem_wdata_o    = core_wdata_i;
        mem_funct_o    = core_funct_i;
        mem_we_funct_o = core_we_funct_i;
        core_gnt_o     = core_req_i;
      end else begin
        mem_en_o    = (state == ST_ISSUE);
        mem_we_o    = (state == ST_ISSUE);
        mem_addr_o  = pre_addr;
        mem_be_o    = '1;
        mem_wdata_o = word;
      end
    end
  end

  assign src_ready_o    = (state == ST_WAIT_SRC);
  assign busy_o         = !in_pass;
  assign done_o         = (state == ST_DONE);
  assign error_o        = (state == ST_ERROR);
  assign fetch_enable_o = fetch_seen || (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rt_lim_preload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rt_lim_preload_ctrl
// Purpose  : Self-checking bench for rt_lim_preload_ctrl with a port-B memory
//            model and a transaction-level expectation of preload writes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rt_lim_preload_ctrl;

  localparam int AW   = 22;
  localparam int DW   = 32;
  localparam int FW   = 4;
  localparam int MW   = 4153;
  localparam int TO   = 16;
  localparam int NW   = $clog2(MW+1);
  localparam logic [AW-1:0] BASE = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] num_words;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          core_req;
  logic [AW-1:0] core_addr;
  logic          core_we;
  logic [3:0]    core_be;
  logic [DW-1:0] core_wdata;
  logic [FW-1:0] core_funct;
  logic          core_we_funct;
  logic          core_gnt;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic [FW-1:0] mem_funct;
  logic          mem_we_funct;
  logic          mem_rvalid = 1'b0;
  logic          busy, done, error, fetch_en;

  rt_lim_preload_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FUNCT_WIDTH(FW), .MAX_WORDS(MW),
    .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_words_i(num_words),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(src_ready),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_we_i(core_we),
    .core_be_i(core_be), .core_wdata_i(core_wdata), .core_funct_i(core_funct),
    .core_we_funct_i(core_we_funct), .core_gnt_o(core_gnt),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_funct_o(mem_funct), .mem_we_funct_o(mem_we_funct),
    .mem_rvalid_i(mem_rvalid), .busy_o(busy), .done_o(done), .error_o(error),
    .fetch_enable_o(fetch_en)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- port-B memory model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    be;
    logic [FW-1:0] funct;
    logic          we;
    logic          wef;
    int            c;
  } wr_t;

  int            lat_cfg = 2;     // rvalid latency after en; 0 = never answer
  int            pend_q[$];
  logic [DW-1:0] mem [0:255];
  wr_t           wr_log[$];       // port-B accesses issued while busy
  int            core_en_cyc = 0; // cycle of the latest core access
  logic          prev_pre_en = 1'b0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rst) begin
      pend_q.delete();
      prev_pre_en = 1'b0;
    end else begin
      foreach (pend_q[i]) pend_q[i]--;
      if (pend_q.size() > 0 && pend_q[0] <= 0) begin
        mem_rvalid = 1'b1;
        void'(pend_q.pop_front());
      end
      if (busy && core_req) chk("gnt_while_busy", core_gnt, 0);
      if (mem_en) begin
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        if (lat_cfg > 0) pend_q.push_back(lat_cfg);
        if (busy) begin
          wr_log.push_back('{mem_addr, mem_wdata, mem_be, mem_funct, mem_we, mem_we_funct, cyc});
          chk("en_single_cycle", prev_pre_en, 0);
          chk("src_ready_in_issue", src_ready, 0);
        end else begin
          core_en_cyc = cyc;
        end
      end
      prev_pre_en = mem_en && busy;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [DW-1:0] src_words[$];

  task automatic send_word(input logic [DW-1:0] d, input int stall);
    bit got;
    repeat (stall) @(posedge clk);
    #1;
    src_valid = 1'b1;
    src_data  = d;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (src_ready) begin
        got = 1'b1;
        chk("ready_state", {busy, mem_en}, 2'b10);
      end
    end
    chk("src_accept", got, 1);
    @(posedge clk); #1;
    src_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      if (done || error) hit = 1'b1;
    end
    chk("end_reached", hit, 1);
    @(posedge clk); #1;
  endtask

  // Runs a full preload of src_words and checks it against the expected
  // write stream: word i lands at BASE + 4*i, plain full-word write.
  task automatic run_preload(input int stall, input int lat, input bit rnd,
                             input bit poke_start);
    int n, st, gap;
    n = src_words.size();
    wr_log.delete();
    lat_cfg   = lat;
    num_words = NW'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    foreach (src_words[i]) begin
      st = rnd ? $urandom_range(0, stall) : stall;
      send_word(src_words[i], st);
      if (poke_start && i == 0) begin
        num_words = NW'(1);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    wait_end(300);
    chk("pre_done", {done, fetch_en, busy, error}, 4'b1100);
    chk("pre_wr_count", wr_log.size(), n);
    foreach (wr_log[i]) begin
      if (i < n) begin
        chk("pre_wr_ctl", {wr_log[i].addr, wr_log[i].be, wr_log[i].funct, wr_log[i].we, wr_log[i].wef},
            {AW'(BASE + AW'(4*i)), 4'hF, 4'h0, 1'b1, 1'b0});
        chk("pre_wr_data", wr_log[i].data, src_words[i]);
        chk("readback", mem[(BASE[9:0] + 10'(4*i)) >> 2], src_words[i]);
        if (i > 0 && !rnd && stall > 0) begin
          gap = wr_log[i].c - wr_log[i-1].c;
          chk("en_spacing", gap >= stall + 1, 1);
        end
      end
    end
  endtask

  // ---------------- passthrough vectors ----------------
  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic [FW-1:0] funct;
    logic          wef;
    logic [1:0]    exp_en_gnt;
  } pvec_t;

  pvec_t pv[6];

  task automatic apply_pvec(input pvec_t v);
    core_req = v.req; core_addr = v.addr; core_we = v.we; core_be = v.be;
    core_wdata = v.wdata; core_funct = v.funct; core_we_funct = v.wef;
    @(negedge clk);
    chk("pass_en_gnt", {mem_en, core_gnt}, v.exp_en_gnt);
    chk("pass_ctl", {mem_addr, mem_we, mem_be, mem_funct, mem_we_funct},
        {v.addr, v.we, v.be, v.funct, v.wef});
    chk("pass_wdata", mem_wdata, v.wdata);
    @(posedge clk); #1;
    core_req = 1'b0;
  endtask

  task automatic idle_core;
    core_req = 1'b0; core_addr = '0; core_we = 1'b0; core_be = '0;
    core_wdata = '0; core_funct = '0; core_we_funct = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    pv[0] = '{1'b1, 22'h000100, 1'b1, 4'hF, 32'hDEADBEEF, 4'h0, 1'b0, 2'b11};
    pv[1] = '{1'b1, 22'h3FFFFC, 1'b0, 4'h3, 32'h00000000, 4'h5, 1'b1, 2'b11};
    pv[2] = '{1'b0, 22'h000040, 1'b1, 4'h1, 32'hA5A5A5A5, 4'hA, 1'b0, 2'b00};
    pv[3] = '{1'b1, 22'h000204, 1'b1, 4'h8, 32'h12345678, 4'hF, 1'b1, 2'b11};
    pv[4] = '{1'b1, 22'h155554, 1'b0, 4'h6, 32'hFFFFFFFF, 4'h1, 1'b0, 2'b11};
    pv[5] = '{1'b0, 22'h0002A8, 1'b0, 4'h0, 32'h0F0F0F0F, 4'h0, 1'b1, 2'b00};

    rst = 1'b1; start = 1'b0; num_words = '0; src_valid = 1'b0; src_data = '0;
    idle_core();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs_a", {mem_en, mem_we, mem_be, mem_funct, mem_we_funct, core_gnt, src_ready,
                       busy, done, error, fetch_en}, '0);
    chk("rst_outs_b", {mem_addr, mem_wdata}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {mem_en, core_gnt, src_ready, busy, done, error, fetch_en}, '0);
    @(posedge clk); #1;

    // Core passthrough in IDLE.
    lat_cfg = 2;
    foreach (pv[i]) apply_pvec(pv[i]);
    repeat (4) @(posedge clk); #1;

    // rvalid never arrives: timeout after 16 waiting cycles, fetch stays off.
    src_words = '{32'hCAFE0001, 32'hCAFE0002};
    wr_log.delete();
    lat_cfg = 0; num_words = NW'(2); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    send_word(32'hCAFE0001, 0);
    @(negedge clk);
    chk("to_issue_en", mem_en, 1);
    repeat (TO) @(posedge clk);
    @(negedge clk);
    chk("to_not_yet", {error, busy}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk("to_error", {error, fetch_en, busy, done}, 4'b1000);
    @(posedge clk); #1;
    lat_cfg = 2;
    apply_pvec(pv[3]);
    repeat (4) @(posedge clk); #1;

    // Fresh reset, then the basic three-word preload.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
    src_words = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_preload(0, 4, 1'b0, 1'b0);

    // Zero words: done within 3 cycles, no port-B pulse.
    wr_log.delete();
    num_words = '0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 3 && !hit; k++) begin
        @(negedge clk);
        if (done) hit = 1'b1;
      end
      chk("zero_done", hit, 1);
    end
    chk("zero_no_en", wr_log.size(), 0);
    @(posedge clk); #1;

    // Core write outstanding when start fires; preload must wait for it.
    lat_cfg = 6;
    core_req = 1'b1; core_we = 1'b1; core_addr = 22'h000300; core_be = 4'hF;
    core_wdata = 32'h0BADF00D;
    @(negedge clk);
    chk("core_gnt_done", core_gnt, 1);
    @(posedge clk); #1;
    idle_core();
    src_words = '{32'hAAAA0000, 32'hBBBB1111};
    fork
      run_preload(0, 4, 1'b0, 1'b0);
      begin
        @(posedge clk); #1;
        core_req = 1'b1; core_addr = 22'h000400;
        repeat (4) @(posedge clk);
        #1 core_req = 1'b0;
      end
    join
    chk("drain_wait", wr_log[0].c > core_en_cyc + 6, 1);

    // Source stalls 10 cycles per word; start while busy must be ignored.
    src_words = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    run_preload(10, 3, 1'b0, 1'b1);

    // Randomized preloads against the transaction-level expectation.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 6);
      src_words.delete();
      for (int j = 0; j < n; j++) src_words.push_back($urandom);
      run_preload(3, $urandom_range(1, 5), 1'b1, r[0]);
    end

    // Reset during WAIT_VALID of word 2, then re-preload from BASE.
    wr_log.delete();
    lat_cfg = 4; num_words = NW'(3); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    send_word(32'h5A5A0001, 0);
    send_word(32'h5A5A0002, 0);
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_a", {mem_en, mem_we, mem_be, mem_funct, mem_we_funct, core_gnt, src_ready,
                        busy, done, error, fetch_en}, '0);
    chk("async_rst_b", {mem_addr, mem_wdata}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    src_words = '{32'h77777777, 32'h88888888};
    run_preload(1, 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
